spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per transfer (>=2).
REQ-002 SHALL have parameter HALF_PERIOD, default 4, clk cycles per sclk half-period (>=1).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  transfer request, sampled when busy=0.
REQ-006 SHALL have port txData  input  WIDTH  word to send, MSB first.
REQ-007 SHALL have port miso  input  1  serial data from peripheral.
REQ-008 SHALL have port sclk  output  1  serial clock, idle low (mode 0).
REQ-009 SHALL have port cs_n  output  1  chip select, active low.
REQ-010 SHALL have port mosi  output  1  serial data to peripheral.
REQ-011 SHALL have port rxData  output  WIDTH  last received word.
REQ-012 SHALL have port busy  output  1  transfer in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL be a registered FSM with states IDLE, SETUP, HIGH, LOW; all outputs are registered.
REQ-015 IDLE: start=1 SHALL capture txData, enter SETUP next cycle: cs_n=0, busy=1, mosi=txData[WIDTH-1], sclk=0.
REQ-016 SETUP, HIGH, LOW SHALL each last exactly HALF_PERIOD clk cycles, timed by a half-period counter reloaded on every state change.
REQ-017 Entering HIGH: sclk=1; miso SHALL be shifted into the receive register LSB at that same clk edge.
REQ-018 Entering LOW: sclk=0; mosi SHALL advance to the next lower tx bit; after the final bit, mosi holds last value.
REQ-019 HIGH/LOW pairs SHALL repeat exactly WIDTH times; the final LOW phase is the cs_n hold time.
REQ-020 End of final LOW: cs_n=1, busy=0, done=1 for one cycle, rxData updated with received word, FSM to IDLE.
REQ-021 cs_n SHALL be low exactly (2*WIDTH+1)*HALF_PERIOD cycles (68 at defaults); exactly WIDTH sclk rising edges per transfer.
REQ-022 start while busy=1 SHALL be ignored; txData changes during transfer SHALL not affect mosi.
REQ-023 start in the done cycle SHALL be accepted (back-to-back); cs_n then high exactly one cycle between transfers.
REQ-024 rxData SHALL hold its value between transfers and change only in the done cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, sclk=0, cs_n=1, mosi=0, busy=0, done=0, rxData=0, counters 0, independent of clk.
REQ-026 Reset mid-transfer SHALL abort without done pulse; the first start after rst_n release SHALL perform a full normal transfer.

Structure
REQ-027 State encoding and default WIDTH/HALF_PERIOD constants SHALL live in shared package spi_pkg, reused by the peripheral-side shift register bench.
REQ-028 Half-period timing SHALL be one sub-module, spi_tick_gen (loadable down-counter, tick at terminal count); bit counter and shift registers stay in spi_master.

Verification
REQ-029 Reset: assert rst_n=0 mid-clock -> sclk=0, cs_n=1, mosi=0, busy=0, done=0, rxData=0 before next clk edge.
REQ-030 Loopback miso=mosi, txData=0xA5, start 1 cycle -> mosi bits 1,0,1,0,0,1,0,1 at sclk rises, 8 sclk pulses, done 68 cycles after cs_n fall, rxData=0xA5.
REQ-031 miso tied 1, txData=0x00 -> mosi constantly 0, rxData=0xFF, done exactly once.
REQ-032 start re-asserted at cycles 10 and 40 of a transfer with txData=0xFF -> ignored; mosi still follows originally captured 0x3C.
REQ-033 rst_n pulsed low at cycle 20 of a transfer -> cs_n=1 immediately, no done; next start with 0x5A -> loopback rxData=0x5A.
REQ-034 HALF_PERIOD=1, 8-bit peripheral shift-register model (parallel-load 0x81, MSB out on sclk fall), back-to-back starts 0x80 then 0x01 -> rxData 0x81 then 0x80, cs_n high one cycle between.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default word/timing constants.
// Reused by the master and by peripheral-side shift register benches.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } spi_state_e;

   localparam int SPI_WIDTH       = 8;
   localparam int SPI_HALF_PERIOD = 4;

   // Counter width that still works when the count range collapses to one value.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: loadable down-counter, tick high while the count is zero.
// Latency: tick HALF_PERIOD-1 cycles after load; no backpressure.
module spi_tick_gen
   import spi_pkg::*;
#(
   parameter int HALF_PERIOD = SPI_HALF_PERIOD
)(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic tick
);

   localparam int            CW     = cnt_width(HALF_PERIOD);
   localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = RELOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one WIDTH-bit full-duplex transfer per start, MSB first.
// Latency: cs_n low (2*WIDTH+1)*HALF_PERIOD cycles; start ignored while busy.
module spi_master
   import spi_pkg::*;
#(
   parameter int WIDTH       = SPI_WIDTH,
   parameter int HALF_PERIOD = SPI_HALF_PERIOD
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] txData,
   input  logic             miso,
   output logic             sclk,
   output logic             cs_n,
   output logic             mosi,
   output logic [WIDTH-1:0] rxData,
   output logic             busy,
   output logic             done
);

   localparam int            BW       = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [BW-1:0] ALL_BITS = BW'(WIDTH);

   spi_state_e       state_q, state_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             sclk_q, sclk_d;
   logic             cs_n_q, cs_n_d;
   logic             mosi_q, mosi_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load;
   logic             tick;

   spi_tick_gen #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .tick  (tick)
   );

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      bit_cnt_d  = bit_cnt_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      load       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SETUP;
               load      = 1'b1;
               tx_d      = txData;
               mosi_d    = txData[WIDTH-1];
               bit_cnt_d = '0;
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
               sclk_d    = 1'b0;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               state_d    = ST_HIGH;
               load       = 1'b1;
               sclk_d     = 1'b1;
               rx_shift_d = (rx_shift_q << 1) | WIDTH'(miso);
            end
         end
         ST_HIGH: begin
            if (tick) begin
               state_d   = ST_LOW;
               load      = 1'b1;
               sclk_d    = 1'b0;
               bit_cnt_d = bit_cnt_q + BW'(1);
               // After the last bit mosi simply keeps its value through the hold phase.
               if (bit_cnt_q != LAST_BIT) begin
                  tx_d   = tx_q << 1;
                  mosi_d = tx_q[WIDTH-2];
               end
            end
         end
         ST_LOW: begin
            if (tick) begin
               load = 1'b1;
               if (bit_cnt_q == ALL_BITS) begin
                  state_d   = ST_IDLE;
                  cs_n_d    = 1'b1;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  rx_data_d = rx_shift_q;
               end else begin
                  state_d    = ST_HIGH;
                  sclk_d     = 1'b1;
                  rx_shift_d = (rx_shift_q << 1) | WIDTH'(miso);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tx_q       <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         bit_cnt_q  <= bit_cnt_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign sclk   = sclk_q;
   assign cs_n   = cs_n_q;
   assign mosi   = mosi_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign rxData = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default timing instance plus a HALF_PERIOD=1
// instance talking to a peripheral shift-register model.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start = 1'b0;
   logic [7:0] txData = 8'h00;
   logic       miso;
   logic       sclk, cs_n, mosi, busy, done;
   logic [7:0] rxData;
   logic       miso_one = 1'b0;

   logic       start1 = 1'b0;
   logic [7:0] txData1 = 8'h00;
   logic       miso1;
   logic       sclk1, cs_n1, mosi1, busy1, done1;
   logic [7:0] rxData1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign miso = miso_one ? 1'b1 : mosi;

   spi_master #(.WIDTH(8), .HALF_PERIOD(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .txData(txData), .miso(miso),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .rxData(rxData), .busy(busy), .done(done)
   );

   spi_master #(.WIDTH(8), .HALF_PERIOD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .txData(txData1), .miso(miso1),
      .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .rxData(rxData1), .busy(busy1), .done(done1)
   );

   // Peripheral: captures mosi after sclk rises, shifts (new MSB out) after sclk falls.
   logic [7:0] p_reg;
   logic       p_in;
   logic       p_load = 1'b0;
   logic       sclk1_prev;

   assign miso1 = p_reg[7];

   always @(negedge clk) begin
      sclk1_prev <= sclk1;
      if (p_load) begin
         p_reg <= 8'h81;
      end else begin
         if (!sclk1_prev && sclk1) p_in <= mosi1;
         if (sclk1_prev && !sclk1) p_reg <= {p_reg[6:0], p_in};
      end
   end

   task automatic run_xfer(input logic [7:0] tx, input bit inject,
                           output logic [7:0] mbits, output int rises, output int cs_low,
                           output int dones, output int gap, output int mosi_ones);
      int   first_low;
      logic prev_sclk;
      mbits = 8'h00; rises = 0; cs_low = 0; dones = 0; gap = -1; mosi_ones = 0;
      first_low = -1; prev_sclk = 1'b0;
      @(negedge clk);
      txData = tx;
      start  = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (!cs_n) begin
            cs_low++;
            if (first_low < 0) first_low = i;
         end
         if (sclk && !prev_sclk) begin
            rises++;
            mbits = {mbits[6:0], mosi};
         end
         prev_sclk = sclk;
         if (mosi) mosi_ones++;
         if (done) begin
            dones++;
            gap = i - first_low;
         end
         if (inject) begin
            if (i == 10 || i == 40) begin
               start  = 1'b1;
               txData = 8'hFF;
            end else begin
               start = 1'b0;
            end
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (sclk !== 1'b0)     begin n_fail++; $display("FAIL reset_sclk got %b want 0", sclk); end
      n_checks++; if (cs_n !== 1'b1)     begin n_fail++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
      n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (rxData !== 8'h00)  begin n_fail++; $display("FAIL reset_rxdata got %h want 00", rxData); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txData = 8'hFF;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (sclk !== 1'b1 || mosi !== 1'b1 || busy !== 1'b1)
         begin n_fail++; $display("FAIL pre_reset_active got sclk=%b mosi=%b busy=%b want 1 1 1", sclk, mosi, busy); end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (sclk !== 1'b0)     begin n_fail++; $display("FAIL async_sclk got %b want 0", sclk); end
      n_checks++; if (cs_n !== 1'b1)     begin n_fail++; $display("FAIL async_cs_n got %b want 1", cs_n); end
      n_checks++; if (mosi !== 1'b0)     begin n_fail++; $display("FAIL async_mosi got %b want 0", mosi); end
      n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL async_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL async_done got %b want 0", done); end
      n_checks++; if (rxData !== 8'h00)  begin n_fail++; $display("FAIL async_rxdata got %h want 00", rxData); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_loopback();
      logic [7:0] mb;
      int r, cl, d, g, mo;
      run_xfer(8'hA5, 1'b0, mb, r, cl, d, g, mo);
      n_checks++; if (mb !== 8'hA5)    begin n_fail++; $display("FAIL loop_mosi_bits got %h want a5", mb); end
      n_checks++; if (r != 8)          begin n_fail++; $display("FAIL loop_sclk_rises got %0d want 8", r); end
      n_checks++; if (cl != 68)        begin n_fail++; $display("FAIL loop_cs_low got %0d want 68", cl); end
      n_checks++; if (g != 68)         begin n_fail++; $display("FAIL loop_done_gap got %0d want 68", g); end
      n_checks++; if (d != 1)          begin n_fail++; $display("FAIL loop_done_count got %0d want 1", d); end
      n_checks++; if (rxData !== 8'hA5) begin n_fail++; $display("FAIL loop_rxdata got %h want a5", rxData); end
   endtask

   task automatic test_miso_ones();
      logic [7:0] mb;
      int r, cl, d, g, mo;
      miso_one = 1'b1;
      run_xfer(8'h00, 1'b0, mb, r, cl, d, g, mo);
      miso_one = 1'b0;
      n_checks++; if (mo != 0)          begin n_fail++; $display("FAIL ones_mosi_high got %0d want 0", mo); end
      n_checks++; if (rxData !== 8'hFF) begin n_fail++; $display("FAIL ones_rxdata got %h want ff", rxData); end
      n_checks++; if (d != 1)           begin n_fail++; $display("FAIL ones_done_count got %0d want 1", d); end
   endtask

   task automatic test_start_ignored();
      logic [7:0] mb;
      int r, cl, d, g, mo;
      run_xfer(8'h3C, 1'b1, mb, r, cl, d, g, mo);
      n_checks++; if (mb !== 8'h3C)     begin n_fail++; $display("FAIL ign_mosi_bits got %h want 3c", mb); end
      n_checks++; if (r != 8)           begin n_fail++; $display("FAIL ign_sclk_rises got %0d want 8", r); end
      n_checks++; if (cl != 68)         begin n_fail++; $display("FAIL ign_cs_low got %0d want 68", cl); end
      n_checks++; if (d != 1)           begin n_fail++; $display("FAIL ign_done_count got %0d want 1", d); end
      n_checks++; if (rxData !== 8'h3C) begin n_fail++; $display("FAIL ign_rxdata got %h want 3c", rxData); end
   endtask

   task automatic test_abort();
      logic [7:0] mb;
      int r, cl, d, g, mo;
      int stray;
      @(negedge clk);
      txData = 8'hC3;
      start  = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
      end
      n_checks++; if (cs_n !== 1'b0)    begin n_fail++; $display("FAIL abort_pre_cs_n got %b want 0", cs_n); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (cs_n !== 1'b1)    begin n_fail++; $display("FAIL abort_cs_n got %b want 1", cs_n); end
      n_checks++; if (rxData !== 8'h00) begin n_fail++; $display("FAIL abort_rxdata got %h want 00", rxData); end
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done || !cs_n) stray++;
      end
      n_checks++; if (stray != 0)       begin n_fail++; $display("FAIL abort_no_done got %0d active cycles want 0", stray); end
      run_xfer(8'h5A, 1'b0, mb, r, cl, d, g, mo);
      n_checks++; if (rxData !== 8'h5A) begin n_fail++; $display("FAIL abort_next_rxdata got %h want 5a", rxData); end
      n_checks++; if (d != 1 || r != 8) begin n_fail++; $display("FAIL abort_next_xfer got done=%0d rises=%0d want 1 8", d, r); end
   endtask

   task automatic test_back_to_back();
      int k;
      p_load = 1'b1;
      repeat (2) @(negedge clk);
      p_load = 1'b0;
      @(negedge clk);
      txData1 = 8'h80;
      start1  = 1'b1;
      @(negedge clk);
      n_checks++; if (cs_n1 !== 1'b0)    begin n_fail++; $display("FAIL b2b_first_cs_n got %b want 0", cs_n1); end
      txData1 = 8'h01;
      k = 0;
      while (!done1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_checks++; if (k != 17)           begin n_fail++; $display("FAIL b2b_first_len got %0d want 17", k); end
      n_checks++; if (rxData1 !== 8'h81) begin n_fail++; $display("FAIL b2b_first_rxdata got %h want 81", rxData1); end
      n_checks++; if (cs_n1 !== 1'b1)    begin n_fail++; $display("FAIL b2b_gap_cs_n got %b want 1", cs_n1); end
      @(negedge clk);
      n_checks++; if (cs_n1 !== 1'b0 || busy1 !== 1'b1)
         begin n_fail++; $display("FAIL b2b_second_start got cs_n=%b busy=%b want 0 1", cs_n1, busy1); end
      start1 = 1'b0;
      k = 0;
      while (!done1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_checks++; if (k != 17)           begin n_fail++; $display("FAIL b2b_second_len got %0d want 17", k); end
      n_checks++; if (rxData1 !== 8'h80) begin n_fail++; $display("FAIL b2b_second_rxdata got %h want 80", rxData1); end
      repeat (2) @(negedge clk);
      n_checks++; if (p_reg !== 8'h01)   begin n_fail++; $display("FAIL b2b_periph_rx got %h want 01", p_reg); end
      n_checks++; if (rxData1 !== 8'h80) begin n_fail++; $display("FAIL b2b_rxdata_hold got %h want 80", rxData1); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_miso_ones();
      test_start_ignored();
      test_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
